bfifo_pad_strip: RTL and testbench

//  Reader-side companion to the boundary padding logic of the block FIFO. The writer pads edge

---
 rtl/bfifo_pad_strip.sv | 113 +++++++++++
 tb/tb_bfifo_pad_strip.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/bfifo_pad_strip.sv
// Reader-side pad stripper for the block FIFO.
// Takes a per-CTB header {real count, pad count} followed by the padded beat
// stream, forwards the real beats with zero latency and silently swallows the
// trailing pad beats. Length mismatches against in_last are flagged sticky.
module bfifo_pad_strip #(
   parameter int DW     = 8,
   parameter int DATA_W = 64,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              hdr_valid,
   output logic              hdr_ready,
   input  logic [CNT_W-1:0]  hdr_real_cnt,
   input  logic [DW-1:0]     hdr_pad_cnt,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic              busy,
   output logic              err_len,
   output logic [15:0]       drop_total
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] PASS = 2'd1;
   localparam logic [1:0] DROP = 2'd2;

   logic [1:0]       state;
   logic [CNT_W-1:0] real_rem;
   logic [DW-1:0]    pad_rem;
   logic             in_fire;
   logic             beat_final;

   // Handshake steering: pass-through in PASS, unconditional sink in DROP.
   always_comb begin
      hdr_ready  = 1'b0;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      out_last   = 1'b0;
      beat_final = 1'b0;
      out_data   = in_data;
      busy       = (state != IDLE);
      case (state)
         IDLE: hdr_ready = 1'b1;
         PASS: begin
            in_ready   = out_ready;
            out_valid  = in_valid;
            out_last   = (real_rem == CNT_W'(1));
            beat_final = (real_rem == CNT_W'(1)) && (pad_rem == '0);
         end
         DROP: begin
            in_ready   = 1'b1;
            beat_final = (pad_rem == DW'(1));
         end
         default: ;
      endcase
      in_fire = in_valid && in_ready;
   end

   // CTB sequencing: counts come from the header, never from in_last.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         real_rem   <= '0;
         pad_rem    <= '0;
         drop_total <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (hdr_valid) begin
                  real_rem <= hdr_real_cnt;
                  pad_rem  <= hdr_pad_cnt;
                  if (hdr_real_cnt != '0)
                     state <= PASS;
                  else if (hdr_pad_cnt != '0)
                     state <= DROP;
               end
            end
            PASS: begin
               if (in_fire) begin
                  real_rem <= real_rem - CNT_W'(1);
                  if (real_rem == CNT_W'(1))
                     state <= (pad_rem != '0) ? DROP : IDLE;
               end
            end
            DROP: begin
               if (in_fire) begin
                  pad_rem <= pad_rem - DW'(1);
                  if (drop_total != '1)
                     drop_total <= drop_total + 16'd1;
                  if (pad_rem == DW'(1))
                     state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Sticky length error: in_last must coincide exactly with the final beat.
   always_ff @(posedge clk) begin
      if (rst)
         err_len <= 1'b0;
      else if (in_fire && (beat_final != in_last))
         err_len <= 1'b1;
   end

endmodule

// File: tb/tb_bfifo_pad_strip.sv
// Randomized bench for bfifo_pad_strip with a transaction-level reference model.
module tb_bfifo_pad_strip;

   logic        clk = 1'b0;
   logic        rst;
   logic        hdr_valid;
   logic        hdr_ready;
   logic [7:0]  hdr_real_cnt;
   logic [7:0]  hdr_pad_cnt;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_data;
   logic        in_last;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_data;
   logic        out_last;
   logic        busy;
   logic        err_len;
   logic [15:0] drop_total;

   int total = 0;
   int bad   = 0;

   // Reference model state
   logic [63:0] exp_data[$];
   logic        exp_last[$];
   int          drop_exp = 0;
   logic        err_exp  = 1'b0;

   bfifo_pad_strip #(.DW(8), .DATA_W(64), .CNT_W(8)) dut (
      .clk(clk), .rst(rst),
      .hdr_valid(hdr_valid), .hdr_ready(hdr_ready),
      .hdr_real_cnt(hdr_real_cnt), .hdr_pad_cnt(hdr_pad_cnt),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
      .busy(busy), .err_len(err_len), .drop_total(drop_total)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Output monitor: every downstream handshake must match the next expected real beat.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (exp_data.size() == 0) begin
            check_val("extra_beat", 64'd1, 64'd0);
         end else begin
            check_val("out_data", out_data, exp_data.pop_front());
            check_val("out_last", {63'd0, out_last}, {63'd0, exp_last.pop_front()});
         end
      end
   end

   task automatic send_hdr(input int r, input int p);
      int n;
      hdr_real_cnt = 8'(r);
      hdr_pad_cnt  = 8'(p);
      hdr_valid    = 1'b1;
      n = 0;
      forever begin
         @(negedge clk);
         if (hdr_ready) break;
         n++;
         if (n > 20) begin
            check_val("hdr_timeout", 64'd0, 64'd1);
            break;
         end
      end
      @(posedge clk); #1;
      hdr_valid = 1'b0;
   endtask

   task automatic send_beat(input logic [63:0] d, input bit last, input bit pad,
                            input bit stall, input bit rnd);
      int n;
      int stalls;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      n = 0;
      stalls = 0;
      forever begin
         if (pad)
            out_ready = 1'($urandom_range(0, 1));
         else if (stall && stalls < 3) begin
            out_ready = 1'b0;
            stalls++;
         end else if (rnd && n < 20)
            out_ready = ($urandom_range(0, 3) != 0);
         else
            out_ready = 1'b1;
         @(negedge clk);
         if (pad) begin
            check_val("drop_rdy", {63'd0, in_ready}, 64'd1);
            check_val("drop_ov", {63'd0, out_valid}, 64'd0);
         end else begin
            check_val("pass_rdy", {63'd0, in_ready}, {63'd0, out_ready});
            check_val("pass_ov", {63'd0, out_valid}, 64'd1);
         end
         if (in_ready) begin
            @(posedge clk); #1;
            break;
         end
         @(posedge clk); #1;
         n++;
         if (n > 60) begin
            check_val("beat_timeout", 64'd0, 64'd1);
            break;
         end
      end
      in_valid  = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b1;
   endtask

   // One CTB: header plus r+p beats; in_last placed at beat index lastpos.
   task automatic send_ctb(input int r, input int p, input int lastpos,
                           input int stall_beat, input bit rnd);
      logic [63:0] d;
      send_hdr(r, p);
      check_val("busy_hdr", {63'd0, busy}, {63'd0, (r + p) != 0});
      drop_exp = (drop_exp + p > 65535) ? 65535 : drop_exp + p;
      if ((r + p) != 0 && lastpos != r + p - 1)
         err_exp = 1'b1;
      for (int i = 0; i < r + p; i++) begin
         d = {$urandom, $urandom};
         if (i < r) begin
            exp_data.push_back(d);
            exp_last.push_back(i == r - 1);
         end
         send_beat(d, (i == lastpos), (i >= r), (i == stall_beat), rnd);
      end
      @(negedge clk);
      check_val("busy_end", {63'd0, busy}, 64'd0);
      check_val("hdr_rdy_end", {63'd0, hdr_ready}, 64'd1);
      check_val("drop_total", {48'd0, drop_total}, 64'(drop_exp));
      check_val("err_len", {63'd0, err_len}, {63'd0, err_exp});
      @(posedge clk); #1;
   endtask

   task automatic rand_ctb(input bit allow_err);
      int r, p, lp;
      r  = $urandom_range(0, 6);
      p  = $urandom_range(0, 4);
      lp = r + p - 1;
      if (allow_err && $urandom_range(0, 4) == 0)
         lp = $urandom_range(0, r + p + 1) - 1;
      send_ctb(r, p, lp, -1, 1'b1);
   endtask

   task automatic check_idle(input string tag);
      check_val({tag, "_busy"}, {63'd0, busy}, 64'd0);
      check_val({tag, "_ov"}, {63'd0, out_valid}, 64'd0);
      check_val({tag, "_olast"}, {63'd0, out_last}, 64'd0);
      check_val({tag, "_hrdy"}, {63'd0, hdr_ready}, 64'd1);
      check_val({tag, "_drop"}, {48'd0, drop_total}, 64'(drop_exp));
      check_val({tag, "_err"}, {63'd0, err_len}, {63'd0, err_exp});
   endtask

   initial begin
      rst = 1'b1;
      hdr_valid = 1'b0; hdr_real_cnt = '0; hdr_pad_cnt = '0;
      in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_idle("reset");
      check_val("reset_irdy", {63'd0, in_ready}, 64'd0);
      @(posedge clk); #1;

      // Beat offered while IDLE must be held upstream
      in_valid = 1'b1; in_data = 64'hdead_beef; in_last = 1'b1;
      repeat (2) begin
         @(negedge clk);
         check_val("idle_irdy", {63'd0, in_ready}, 64'd0);
         check_val("idle_ov", {63'd0, out_valid}, 64'd0);
         @(posedge clk); #1;
      end
      in_valid = 1'b0; in_last = 1'b0;

      send_ctb(4, 0, 3, -1, 1'b0);          // T1
      send_ctb(3, 2, 4, -1, 1'b0);          // T2
      send_ctb(0, 3, 2, -1, 1'b0);          // T3
      send_ctb(0, 0, -1, -1, 1'b0);
      send_ctb(3, 2, 4, 1, 1'b0);           // T4
      send_ctb(1, 1, 1, 0, 1'b0);
      for (int k = 0; k < 30; k++) rand_ctb(1'b0);
      send_ctb(4, 0, 1, -1, 1'b0);          // T5
      for (int k = 0; k < 8; k++) rand_ctb(1'b0);

      // T6: reset in the middle of hdr{8,4}
      send_hdr(8, 4);
      for (int i = 0; i < 2; i++) begin
         logic [63:0] d;
         d = {$urandom, $urandom};
         exp_data.push_back(d);
         exp_last.push_back(1'b0);
         send_beat(d, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      drop_exp = 0;
      err_exp  = 1'b0;
      check_val("t6_leftover", 64'(exp_data.size()), 64'd0);
      exp_data.delete();
      exp_last.delete();
      @(negedge clk);
      check_idle("t6");

      @(posedge clk); #1;
      for (int k = 0; k < 25; k++) rand_ctb(1'b1);

      check_val("queue_empty", 64'(exp_data.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule
